tlb_op_ctrl: RTL

//  Sequencer for TLB maintenance instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB), sitting between the EXE/MEM

---
 rtl/tlb_op_ctrl_if.sv | 48 ++++
 rtl/tlb_op_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl_if.sv
// Pipeline-side bundle of the TLB op sequencer: op request with sampled CSR state, and the CSR write-back.
// master = pipeline (EXE/MEM stage), slave = tlb_op_ctrl.
interface tlb_op_ctrl_if #(
  parameter int TLBNUM = 16
);
  localparam int IW = $clog2(TLBNUM);

  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid;
  logic [18:0]   inv_vppn;
  logic [IW-1:0] csr_idx;
  logic [5:0]    csr_ps;
  logic          csr_ne;
  logic [18:0]   csr_vppn;
  logic [9:0]    csr_asid;
  logic [31:0]   csr_elo0;
  logic [31:0]   csr_elo1;
  logic [5:0]    csr_ecode;

  logic          done;
  logic          wb_idx_we;
  logic          wb_ehi_we;
  logic [IW-1:0] wb_index;
  logic [5:0]    wb_ps;
  logic          wb_ne;
  logic [18:0]   wb_vppn;
  logic [9:0]    wb_asid;
  logic [31:0]   wb_elo0;
  logic [31:0]   wb_elo1;
  logic          ine_excp;

  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vppn,
           csr_idx, csr_ps, csr_ne, csr_vppn, csr_asid, csr_elo0, csr_elo1, csr_ecode,
    input  op_ready, done, wb_idx_we, wb_ehi_we, wb_index, wb_ps, wb_ne,
           wb_vppn, wb_asid, wb_elo0, wb_elo1, ine_excp
  );

  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
           csr_idx, csr_ps, csr_ne, csr_vppn, csr_asid, csr_elo0, csr_elo1, csr_ecode,
    output op_ready, done, wb_idx_we, wb_ehi_we, wb_index, wb_ps, wb_ne,
           wb_vppn, wb_asid, wb_elo0, wb_elo1, ine_excp
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer: IDLE -> EXEC (TLB port strobes) -> RESP (done + CSR write-back).
// Accept at T, done at T+2; op_ready is low from accept until back in IDLE and requests meanwhile are dropped.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  tlb_op_ctrl_if.slave    pl,
  output logic            s1_sel,
  output logic [18:0]     s1_vppn,
  output logic [9:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IW-1:0]   s1_index,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op,
  output logic            we,
  output logic [IW-1:0]   we_index,
  output logic            w_e,
  output logic [18:0]     w_vppn,
  output logic [5:0]      w_ps,
  output logic [9:0]      w_asid,
  output logic            w_g,
  output logic [19:0]     w_ppn0,
  output logic [1:0]      w_plv0,
  output logic [1:0]      w_mat0,
  output logic            w_d0,
  output logic            w_v0,
  output logic [19:0]     w_ppn1,
  output logic [1:0]      w_plv1,
  output logic [1:0]      w_mat1,
  output logic            w_d1,
  output logic            w_v1,
  output logic [IW-1:0]   r_index,
  input  logic            r_e,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  input  logic [9:0]      r_asid,
  input  logic            r_g,
  input  logic [19:0]     r_ppn0,
  input  logic [1:0]      r_plv0,
  input  logic [1:0]      r_mat0,
  input  logic            r_d0,
  input  logic            r_v0,
  input  logic [19:0]     r_ppn1,
  input  logic [1:0]      r_plv1,
  input  logic [1:0]      r_mat1,
  input  logic            r_d1,
  input  logic            r_v1
);
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Only what RESP still needs is kept; everything EXEC drives is registered straight onto its port.
  typedef struct packed {
    logic [2:0]    code;
    logic          bad;
    logic [IW-1:0] idx;
    logic [5:0]    ps;
  } op_lat_t;

  state_t        state;
  op_lat_t       lat;
  logic [IW-1:0] fill_ptr;
  logic          bad_in;

  assign bad_in = (pl.op_code > OP_INV) || ((pl.op_code == OP_INV) && (pl.inv_op > 5'd6));

  function automatic logic [31:0] pack_elo(input logic [19:0] ppn, input logic g,
                                           input logic [1:0] mat, input logic [1:0] plv,
                                           input logic d, input logic v);
    return {4'h0, ppn, 1'b0, g, mat, plv, d, v};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat          <= '0;
      fill_ptr     <= '0;
      pl.op_ready  <= 1'b1;
      pl.done      <= 1'b0;
      pl.wb_idx_we <= 1'b0;
      pl.wb_ehi_we <= 1'b0;
      pl.wb_index  <= '0;
      pl.wb_ps     <= '0;
      pl.wb_ne     <= 1'b0;
      pl.wb_vppn   <= '0;
      pl.wb_asid   <= '0;
      pl.wb_elo0   <= '0;
      pl.wb_elo1   <= '0;
      pl.ine_excp  <= 1'b0;
      s1_sel       <= 1'b0;
      s1_vppn      <= '0;
      s1_asid      <= '0;
      invtlb_valid <= 1'b0;
      invtlb_op    <= '0;
      we           <= 1'b0;
      we_index     <= '0;
      w_e          <= 1'b0;
      w_vppn       <= '0;
      w_ps         <= '0;
      w_asid       <= '0;
      w_g          <= 1'b0;
      w_ppn0       <= '0;
      w_plv0       <= '0;
      w_mat0       <= '0;
      w_d0         <= 1'b0;
      w_v0         <= 1'b0;
      w_ppn1       <= '0;
      w_plv1       <= '0;
      w_mat1       <= '0;
      w_d1         <= 1'b0;
      w_v1         <= 1'b0;
      r_index      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pl.op_valid) begin
            state        <= EXEC;
            pl.op_ready  <= 1'b0;
            lat.code     <= pl.op_code;
            lat.bad      <= bad_in;
            lat.idx      <= pl.csr_idx;
            lat.ps       <= pl.csr_ps;
            s1_sel       <= (pl.op_code == OP_SRCH) || (pl.op_code == OP_INV);
            s1_vppn      <= (pl.op_code == OP_INV) ? pl.inv_vppn : pl.csr_vppn;
            s1_asid      <= (pl.op_code == OP_INV) ? pl.inv_asid : pl.csr_asid;
            invtlb_valid <= (pl.op_code == OP_INV) && !bad_in;
            invtlb_op    <= pl.inv_op;
            we           <= (pl.op_code == OP_WR) || (pl.op_code == OP_FILL);
            we_index     <= (pl.op_code == OP_FILL) ? fill_ptr : pl.csr_idx;
            r_index      <= pl.csr_idx;
            // A refill handler installs the entry regardless of TLBIDX.NE
            w_e          <= (pl.csr_ecode == ECODE_TLBR) || !pl.csr_ne;
            w_vppn       <= pl.csr_vppn;
            w_ps         <= pl.csr_ps;
            w_asid       <= pl.csr_asid;
            w_g          <= pl.csr_elo0[6] & pl.csr_elo1[6];
            w_ppn0       <= pl.csr_elo0[27:8];
            w_mat0       <= pl.csr_elo0[5:4];
            w_plv0       <= pl.csr_elo0[3:2];
            w_d0         <= pl.csr_elo0[1];
            w_v0         <= pl.csr_elo0[0];
            w_ppn1       <= pl.csr_elo1[27:8];
            w_mat1       <= pl.csr_elo1[5:4];
            w_plv1       <= pl.csr_elo1[3:2];
            w_d1         <= pl.csr_elo1[1];
            w_v1         <= pl.csr_elo1[0];
          end
        end
        EXEC: begin
          state        <= RESP;
          s1_sel       <= 1'b0;
          invtlb_valid <= 1'b0;
          we           <= 1'b0;
          pl.done      <= 1'b1;
          pl.ine_excp  <= lat.bad;
          if (lat.code == OP_FILL) fill_ptr <= fill_ptr + IW'(1);
          if (lat.code == OP_SRCH) begin
            pl.wb_idx_we <= 1'b1;
            pl.wb_index  <= s1_found ? s1_index : lat.idx;
            pl.wb_ps     <= lat.ps;
            pl.wb_ne     <= !s1_found;
          end
          if (lat.code == OP_RD) begin
            pl.wb_idx_we <= 1'b1;
            pl.wb_ehi_we <= 1'b1;
            pl.wb_index  <= lat.idx;
            pl.wb_ne     <= !r_e;
            // An invalid entry reads back as all-zero CSR state
            pl.wb_ps     <= r_e ? r_ps : 6'd0;
            pl.wb_vppn   <= r_e ? r_vppn : 19'd0;
            pl.wb_asid   <= r_e ? r_asid : 10'd0;
            pl.wb_elo0   <= r_e ? pack_elo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0) : 32'd0;
            pl.wb_elo1   <= r_e ? pack_elo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1) : 32'd0;
          end
        end
        RESP: begin
          state        <= IDLE;
          pl.op_ready  <= 1'b1;
          pl.done      <= 1'b0;
          pl.wb_idx_we <= 1'b0;
          pl.wb_ehi_we <= 1'b0;
          pl.ine_excp  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          pl.op_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
